// File: rtl/pico_pkg.sv
// pico_pkg -- shared definitions for the instruction fetch unit.
//   state_t       : fetch FSM state encoding
//   OP_SYS        : opcode nibble whose bit 3 selects a two-word form
//   OP_LONG       : opcode nibble that is always a two-word instruction
//   RESET_PC_DEF  : default first fetch address after reset
package pico_pkg;

  typedef enum logic [2:0] {
    FETCH0 = 3'd0,
    WORD0  = 3'd1,
    FETCH1 = 3'd2,
    WORD1  = 3'd3,
    VALID  = 3'd4
  } state_t;

  localparam logic [3:0] OP_SYS  = 4'h0;
  localparam logic [3:0] OP_LONG = 4'h8;

  localparam int RESET_PC_DEF = 8;

endpackage

// File: rtl/instr_len_decode.sv
// instr_len_decode -- combinational long/short classification of the first
// instruction word.
//   word0   : in  16  first word of the instruction
//   is_long : out 1   instruction occupies two memory words
module instr_len_decode
  import pico_pkg::*;
(
  input  logic [15:0] word0,
  output logic        is_long
);

  // Only the opcode nibble and bit 3 matter for length.
  logic unused_bits;
  assign unused_bits = ^{word0[11:4], word0[2:0]};

  always_comb begin
    is_long = (word0[15:12] == OP_LONG) ||
              ((word0[15:12] == OP_SYS) && word0[3]);
  end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch -- fetches one- or two-word instructions from a synchronous
// program memory and presents them to decode with a valid/ready handshake.
// Optional feature: define FETCH_CNT_EN to add the instr_count output.
//   clk          : in  1       clock, rising edge
//   rst          : in  1       synchronous active-high reset
//   mem_addr     : out AW      program memory read address (always pc)
//   mem_in       : in  DW      read data, one cycle after mem_addr
//   redirect     : in  1       load redirect_pc as the new fetch address
//   redirect_pc  : in  AW      redirect target
//   instr_valid  : out 1       instr/instr_pc hold a complete instruction
//   instr_ready  : in  1       decode accepts the instruction
//   instr        : out 2*DW    {word0, word1}, word1 = 0 for short forms
//   instr_pc     : out AW      address of word0
//   pc           : out AW      current fetch pointer
//   instr_count  : out 16      accepted handshakes, saturating (FETCH_CNT_EN)
//
// state  | meaning
// FETCH0 | first word address on mem_addr
// WORD0  | first word on mem_in, captured; length decided
// FETCH1 | second word address on mem_addr
// WORD1  | second word on mem_in, captured
// VALID  | instruction complete, waiting for instr_ready
module instr_fetch
  import pico_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16,
  parameter int RESET_PC   = RESET_PC_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  input  logic [DATA_WIDTH-1:0]   mem_in,
  input  logic                    redirect,
  input  logic [ADDR_WIDTH-1:0]   redirect_pc,
  output logic                    instr_valid,
  input  logic                    instr_ready,
  output logic [2*DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0]   instr_pc,
  output logic [ADDR_WIDTH-1:0]   pc
`ifdef FETCH_CNT_EN
  ,
  output logic [15:0]             instr_count
`endif
);

  state_t state;
  state_t state_next;
  logic   is_long;

  instr_len_decode u_len (
    .word0   (mem_in[15:0]),
    .is_long (is_long)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH0;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (redirect) begin
      state_next = FETCH0;
    end else begin
      case (state)
        FETCH0:  state_next = WORD0;
        WORD0:   state_next = is_long ? FETCH1 : VALID;
        FETCH1:  state_next = WORD1;
        WORD1:   state_next = VALID;
        VALID:   state_next = instr_ready ? FETCH0 : VALID;
        default: state_next = FETCH0;
      endcase
    end
  end

  // The memory is read every cycle at pc, so the address never depends on state.
  always_comb begin
    instr_valid = (state == VALID);
    mem_addr    = pc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= ADDR_WIDTH'(RESET_PC);
      instr    <= '0;
      instr_pc <= '0;
    end else if (redirect) begin
      // Any partly assembled instruction is simply abandoned; it can never
      // be flagged valid because the FSM restarts at FETCH0.
      pc <= redirect_pc;
    end else begin
      case (state)
        WORD0: begin
          instr[2*DATA_WIDTH-1 -: DATA_WIDTH] <= mem_in;
          instr[DATA_WIDTH-1:0]               <= '0;
          instr_pc                            <= pc;
          pc                                  <= pc + ADDR_WIDTH'(1);
        end
        WORD1: begin
          instr[DATA_WIDTH-1:0] <= mem_in;
          pc                    <= pc + ADDR_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef FETCH_CNT_EN
  // A handshake coinciding with redirect still counts as accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_count <= '0;
    end else if (instr_valid && instr_ready && (instr_count != 16'hFFFF)) begin
      instr_count <= instr_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  logic        clk;
  logic        rst;
  logic [5:0]  mem_addr;
  logic [15:0] mem_in;
  logic        redirect;
  logic [5:0]  redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [5:0]  instr_pc;
  logic [5:0]  pc;
`ifdef FETCH_CNT_EN
  logic [15:0] instr_count;
`endif

  instr_fetch #(.ADDR_WIDTH(6), .DATA_WIDTH(16), .RESET_PC(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_addr    (mem_addr),
    .mem_in      (mem_in),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .pc          (pc)
`ifdef FETCH_CNT_EN
    ,
    .instr_count (instr_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous program memory: data for an address appears one cycle later.
  logic [15:0] mem [0:63];
  always @(posedge clk) mem_in <= mem[mem_addr];

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [5:0]  exp_pc;
  int          n_acc    = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit long_ref(input logic [15:0] w);
    logic [3:0] op;
    op = w[15:12];
    return (op == 4'h8) || (op == 4'h0 && w[3] == 1'b1);
  endfunction

  task automatic check_count();
`ifdef FETCH_CNT_EN
    check("instr_count", instr_count, n_acc);
`endif
  endtask

  // Called at the falling edge of a cycle in which the DUT sits in FETCH0.
  // hold      : cycles to keep instr_ready low once valid
  // redir     : abandon this instruction with a redirect
  // redir_raw : reduced modulo latency to pick the redirect cycle
  // acc_redir : redirect in the same cycle as the accepting handshake
  task automatic do_fetch(input int hold, input bit redir, input int redir_raw,
                          input bit acc_redir, input logic [5:0] tgt);
    logic [5:0]  p;
    logic [5:0]  p1;
    logic [15:0] w0;
    logic [15:0] w1;
    logic [31:0] ei;
    logic [5:0]  np;
    bit          lng;
    int          lat;
    int          cnt;
    p   = exp_pc;
    p1  = p + 6'd1;
    w0  = mem[p];
    lng = long_ref(w0);
    w1  = lng ? mem[p1] : 16'h0000;
    ei  = {w0, w1};
    lat = lng ? 4 : 2;
    np  = lng ? p + 6'd2 : p + 6'd1;
    check("fetch_addr", mem_addr, p);
    check("fetch_nvalid", instr_valid, 1'b0);
    if (redir) begin
      for (int i = 0; i < (redir_raw % lat); i++) begin
        @(negedge clk);
        check("partial_nvalid", instr_valid, 1'b0);
      end
      redirect    = 1'b1;
      redirect_pc = tgt;
      @(negedge clk);
      redirect = 1'b0;
      check("redir_nvalid", instr_valid, 1'b0);
      check("redir_addr", mem_addr, tgt);
      check("redir_pc", pc, tgt);
      exp_pc = tgt;
      return;
    end
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!instr_valid && cnt < 8);
    check("latency", cnt, lat);
    check("instr", instr, ei);
    check("instr_pc", instr_pc, p);
    check("pc_after", pc, np);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", instr_valid, 1'b1);
      check("hold_instr", instr, ei);
      check("hold_pc", pc, np);
      check("hold_addr", mem_addr, np);
    end
    instr_ready = 1'b1;
    if (acc_redir) begin
      redirect    = 1'b1;
      redirect_pc = tgt;
    end
    @(negedge clk);
    instr_ready = 1'b0;
    redirect    = 1'b0;
    n_acc++;
    exp_pc = acc_redir ? tgt : np;
    check("acc_nvalid", instr_valid, 1'b0);
    check("next_addr", mem_addr, exp_pc);
    check_count();
  endtask

  initial begin
    logic [31:0] r;
    logic [15:0] w;
    for (int i = 0; i < 64; i++) mem[i] = 16'h1000;
    mem[8]  = 16'h1000;
    mem[9]  = 16'h8000;
    mem[10] = 16'h0020;
    mem[11] = 16'h0004;
    mem[12] = 16'h8abc;
    mem[13] = 16'h5555;
    mem[20] = 16'h000f;
    mem[21] = 16'hbeef;
    mem[63] = 16'h7001;
    mem[0]  = 16'h8123;
    mem[1]  = 16'h4567;

    rst         = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 6'd5;
    instr_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pc", pc, 6'd8);
    check("rst_valid", instr_valid, 1'b0);
    check("rst_instr", instr, 32'h0);
    check("rst_instr_pc", instr_pc, 6'd0);
    check("rst_addr", mem_addr, 6'd8);
    check_count();
    rst      = 1'b0;
    redirect = 1'b0;
    exp_pc   = 6'd8;

    do_fetch(0, 1'b0, 0, 1'b0, 6'd0);   // short at 8
    do_fetch(0, 1'b0, 0, 1'b0, 6'd0);   // long at 9
    do_fetch(5, 1'b0, 0, 1'b0, 6'd0);   // short opcode-0 form, held 5 cycles
    do_fetch(0, 1'b1, 2, 1'b0, 6'd20);  // redirect in FETCH1 of long at 12
    do_fetch(1, 1'b0, 0, 1'b1, 6'd63);  // redirect with accepting handshake
    do_fetch(0, 1'b0, 0, 1'b0, 6'd0);   // short at 63, wraps to 0
    do_fetch(0, 1'b0, 0, 1'b0, 6'd0);   // long at 0

    for (int i = 0; i < 64; i++) begin
      r = $urandom;
      w = r[15:0];
      if (r[17:16] == 2'd0) w[15:12] = 4'h8;
      else if (r[17:16] == 2'd1) w[15:12] = 4'h0;
      mem[i] = w;
    end
    mem[63] = 16'h8001;
    do_fetch(0, 1'b0, 0, 1'b1, 6'd63);  // long at 63 then jump back to 63
    do_fetch(0, 1'b0, 0, 1'b0, 6'd0);   // long at 63, second word from 0

    for (int n = 0; n < 60; n++) begin
      do_fetch($urandom_range(0, 3), ($urandom_range(0, 5) == 0),
               $urandom_range(0, 3), ($urandom_range(0, 7) == 0),
               6'($urandom_range(0, 63)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 6, memory word-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, memory word width.
REQ-003 SHALL have parameter RESET_PC, default 8, first fetch address after reset.
REQ-004 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port mem_addr  output  ADDR_WIDTH  read address to program memory.
REQ-007 SHALL have port mem_in  input  DATA_WIDTH  read data, valid the cycle after mem_addr is presented.
REQ-008 SHALL have port redirect  input  1  load new fetch address (jump/branch/return).
REQ-009 SHALL have port redirect_pc  input  ADDR_WIDTH  target address for redirect.
REQ-010 SHALL have port instr_valid  output  1  instr/instr_pc hold a complete instruction.
REQ-011 SHALL have port instr_ready  input  1  downstream decode accepts the instruction.
REQ-012 SHALL have port instr  output  2*DATA_WIDTH  assembled instruction {word0, word1}.
REQ-013 SHALL have port instr_pc  output  ADDR_WIDTH  address of word0 of instr.
REQ-014 SHALL have port pc  output  ADDR_WIDTH  current fetch pointer.

Function
REQ-015 SHALL run FSM states FETCH0, WORD0, FETCH1, WORD1, VALID.
REQ-016 FETCH0: mem_addr = pc; next WORD0.
REQ-017 WORD0: word0 <= mem_in, instr_pc <= address of word0, pc <= pc+1; next FETCH1 if long, else VALID with word1 <= 0.
REQ-018 Long instruction SHALL be: word0[15:12] == 4'h8, or (word0[15:12] == 4'h0 and word0[3] == 1).
REQ-019 FETCH1: mem_addr = pc; next WORD1.
REQ-020 WORD1: word1 <= mem_in, pc <= pc+1; next VALID.
REQ-021 VALID: instr_valid = 1, instr and instr_pc stable; on instr_ready go to FETCH0, else hold.
REQ-022 Latency from FETCH0 entry to instr_valid SHALL be 2 cycles for short and 4 cycles for long instructions.
REQ-023 In states other than FETCH0/FETCH1, mem_addr SHALL equal pc.
REQ-024 pc SHALL wrap modulo 2^ADDR_WIDTH (63+1 -> 0 at default).
REQ-025 redirect SHALL take priority in every state: pc <= redirect_pc, state <= FETCH0, any partial instruction discarded, instr_valid low on the next cycle.
REQ-026 If redirect and instr_valid&instr_ready occur in the same cycle, the handshake SHALL count as accepted and the next fetch SHALL come from redirect_pc.
REQ-027 instr_valid SHALL never assert for a partially fetched instruction.

Reset
REQ-028 On rst: state FETCH0, pc = RESET_PC, instr_valid = 0, instr = 0, instr_pc = 0; rst overrides redirect.
REQ-029 The first mem_addr after reset deasserts SHALL be RESET_PC.

Configuration
REQ-030 Macro FETCH_CNT_EN defined: output port instr_count (16 bits) SHALL increment on each accepted handshake, saturate at 16'hFFFF, and reset to 0.
REQ-031 Macro FETCH_CNT_EN undefined: port and counter SHALL be absent, with otherwise identical behaviour.

Structure
REQ-032 State encoding, opcode constants (4'h0, 4'h8) and the RESET_PC default SHALL live in shared package pico_pkg.
REQ-033 Long/short decision SHALL be a combinational sub-module instr_len_decode (input word0, output is_long).

Verification
REQ-034 Reset, mem[8]=16'h1000 (short), ready=1 -> mem_addr 8, instr_valid at cycle 2 with instr=32'h1000_0000, instr_pc=8, pc=9.
REQ-035 mem[9]=16'h8000, mem[10]=16'h0020 -> instr=32'h8000_0020, instr_pc=9, valid 4 cycles after FETCH0, pc=11.
REQ-036 instr_valid with ready=0 for 5 cycles -> instr stable, pc unchanged, mem_addr=pc; ready=1 -> FETCH0 next cycle.
REQ-037 redirect=1, redirect_pc=20 in FETCH1 of a long instruction -> no valid for the partial instruction, next mem_addr=20.
REQ-038 pc=63 with a short instruction -> instr_pc=63, next fetch address 0; with FETCH_CNT_EN, instr_count increments once per accepted handshake.
